// File: rtl/csr_scratch_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// csr_scratch_access_ctrl_if
// Bus bundle between the scratch CSR access controller and its neighbours:
// the pipeline CSR request channel, the debug access channel, the scratch
// register block (current values in, select/write/data out) and the response.
//   master : requester side (pipeline, debug unit, scratch storage, response sink)
//   slave  : the access controller
// ---------------------------------------------------------------------------
interface csr_scratch_access_ctrl_if #(
    parameter int DATA_W = 64
);
    // pipeline request
    logic              req_valid;
    logic              req_ready;
    logic [11:0]       req_addr;
    logic [1:0]        req_op;
    logic [DATA_W-1:0] req_wdata;
    logic              req_rs1_zero;
    logic [1:0]        priv;
    // debug request
    logic              dbg_valid;
    logic              dbg_ready;
    logic [11:0]       dbg_addr;
    logic              dbg_write;
    logic [DATA_W-1:0] dbg_wdata;
    // scratch register block
    logic [DATA_W-1:0] mscratch;
    logic [DATA_W-1:0] sscratch;
    logic              mrw_mscratch_sel;
    logic              srw_sscratch_sel;
    logic              csr_write;
    logic [DATA_W-1:0] data_csr;
    // response
    logic              rsp_valid;
    logic              rsp_src;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_illegal;

    modport master (
        output req_valid, req_addr, req_op, req_wdata, req_rs1_zero, priv,
        output dbg_valid, dbg_addr, dbg_write, dbg_wdata,
        output mscratch, sscratch,
        input  req_ready, dbg_ready,
        input  mrw_mscratch_sel, srw_sscratch_sel, csr_write, data_csr,
        input  rsp_valid, rsp_src, rsp_rdata, rsp_illegal
    );

    modport slave (
        input  req_valid, req_addr, req_op, req_wdata, req_rs1_zero, priv,
        input  dbg_valid, dbg_addr, dbg_write, dbg_wdata,
        input  mscratch, sscratch,
        output req_ready, dbg_ready,
        output mrw_mscratch_sel, srw_sscratch_sel, csr_write, data_csr,
        output rsp_valid, rsp_src, rsp_rdata, rsp_illegal
    );
endinterface

// File: rtl/csr_scratch_access_ctrl.sv
// ---------------------------------------------------------------------------
// csr_scratch_access_ctrl
// Sequencer/arbiter in front of the mscratch/sscratch CSR pair. Accepts CSR
// instructions from the pipeline and raw accesses from the debug unit,
// round-robin arbitrates between them, checks privilege/legality and runs the
// RW/RS/RC read-modify-write against the scratch block.
//   clk  : clock
//   rst  : synchronous active-high reset (aborts any access in flight)
//   bus  : slave side of csr_scratch_access_ctrl_if (requests, scratch
//          select/write/data, response)
// Flow: IDLE (handshake) -> READ (decode, capture old) -> [WRITE] -> RESP.
// ---------------------------------------------------------------------------
module csr_scratch_access_ctrl #(
    parameter int          DATA_W        = 64,
    parameter logic [11:0] MSCRATCH_ADDR = 12'h340,
    parameter logic [11:0] SSCRATCH_ADDR = 12'h140
) (
    input  logic                    clk,
    input  logic                    rst,
    csr_scratch_access_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    localparam logic SRC_PIPE = 1'b0;
    localparam logic SRC_DBG  = 1'b1;

    state_e            state_q, state_d;
    logic              ptr_q, ptr_d;      // source that wins a tie
    logic [11:0]       addr_q;
    logic [1:0]        op_q;
    logic [DATA_W-1:0] wdata_q;
    logic              rs1z_q;
    logic              src_q;
    logic [1:0]        priv_q;            // effective privilege of the access
    logic [DATA_W-1:0] old_q;
    logic              ill_q;

    logic              gnt_pipe, gnt_dbg, hs;
    logic              hit_m, hit_s, wr_int, ill_d;
    logic [DATA_W-1:0] old_d, wr_data;

    // Arbitration: the pointer source wins a tie; a lone requester always wins.
    assign gnt_dbg  = (state_q == S_IDLE) && bus.dbg_valid && (ptr_q || !bus.req_valid);
    assign gnt_pipe = (state_q == S_IDLE) && bus.req_valid && !gnt_dbg;
    assign hs       = !rst && (gnt_dbg || gnt_pipe);

    // Decode of the latched access. Debug accesses are latched as op 01 (write)
    // or 00 (read) with rs1z clear, so one write-intent equation covers both
    // sources; the op==00 fault only applies to the pipeline.
    assign hit_m  = (addr_q == MSCRATCH_ADDR);
    assign hit_s  = (addr_q == SSCRATCH_ADDR);
    assign wr_int = (op_q == 2'b01) || (op_q[1] && !rs1z_q);
    assign ill_d  = !(hit_m || hit_s)
                 || (priv_q < addr_q[9:8])
                 || (wr_int && (addr_q[11:10] == 2'b11))
                 || ((src_q == SRC_PIPE) && (op_q == 2'b00));
    assign old_d  = hit_m ? bus.mscratch : (hit_s ? bus.sscratch : '0);

    always_comb begin
        case (op_q)
            2'b10:   wr_data = old_q | wdata_q;
            2'b11:   wr_data = old_q & ~wdata_q;
            default: wr_data = wdata_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= SRC_DBG;
            addr_q  <= '0;
            op_q    <= '0;
            wdata_q <= '0;
            rs1z_q  <= 1'b0;
            src_q   <= SRC_PIPE;
            priv_q  <= '0;
            old_q   <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            if (hs) begin
                if (gnt_dbg) begin
                    addr_q  <= bus.dbg_addr;
                    op_q    <= {1'b0, bus.dbg_write};
                    wdata_q <= bus.dbg_wdata;
                    rs1z_q  <= 1'b0;
                    src_q   <= SRC_DBG;
                    priv_q  <= 2'd3;
                end else begin
                    addr_q  <= bus.req_addr;
                    op_q    <= bus.req_op;
                    wdata_q <= bus.req_wdata;
                    rs1z_q  <= bus.req_rs1_zero;
                    src_q   <= SRC_PIPE;
                    priv_q  <= bus.priv;
                end
            end
            if (state_q == S_READ) begin
                old_q <= old_d;
                ill_q <= ill_d;
            end
        end
    end

    always_comb begin
        state_d              = state_q;
        ptr_d                = ptr_q;
        bus.req_ready        = 1'b0;
        bus.dbg_ready        = 1'b0;
        bus.mrw_mscratch_sel = 1'b0;
        bus.srw_sscratch_sel = 1'b0;
        bus.csr_write        = 1'b0;
        bus.data_csr         = '0;
        bus.rsp_valid        = 1'b0;
        bus.rsp_src          = 1'b0;
        bus.rsp_rdata        = '0;
        bus.rsp_illegal      = 1'b0;
        case (state_q)
            S_IDLE: begin
                bus.req_ready = gnt_pipe;
                bus.dbg_ready = gnt_dbg;
                if (gnt_dbg) begin
                    ptr_d   = SRC_PIPE;
                    state_d = S_READ;
                end else if (gnt_pipe) begin
                    ptr_d   = SRC_DBG;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                state_d = (!ill_d && wr_int) ? S_WRITE : S_RESP;
            end
            S_WRITE: begin
                // Only legal, mapped addresses reach WRITE, so exactly one hit.
                bus.mrw_mscratch_sel = hit_m;
                bus.srw_sscratch_sel = hit_s && !hit_m;
                bus.csr_write        = 1'b1;
                bus.data_csr         = wr_data;
                state_d              = S_RESP;
            end
            S_RESP: begin
                bus.rsp_valid   = 1'b1;
                bus.rsp_src     = src_q;
                bus.rsp_rdata   = ill_q ? '0 : old_q;
                bus.rsp_illegal = ill_q;
                state_d         = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Reset aborts the access within the reset cycle itself: nothing is
        // written or responded to while rst is high.
        if (rst) begin
            bus.req_ready        = 1'b0;
            bus.dbg_ready        = 1'b0;
            bus.mrw_mscratch_sel = 1'b0;
            bus.srw_sscratch_sel = 1'b0;
            bus.csr_write        = 1'b0;
            bus.data_csr         = '0;
            bus.rsp_valid        = 1'b0;
            bus.rsp_src          = 1'b0;
            bus.rsp_rdata        = '0;
            bus.rsp_illegal      = 1'b0;
        end
    end
endmodule

// File: doc/csr_scratch_access_ctrl.md
Name: csr_scratch_access_ctrl

Overview:
- Sequencer and arbiter in front of the machine/supervisor scratch CSR pair.
- Accepts CSR instructions from the pipeline and raw accesses from the debug unit, and arbitrates between them.
- Decodes the address, checks privilege and legality, and performs the read-modify-write (RW/RS/RC).
- Drives the scratch block's select lines, csr_write and data_csr; returns the old value and an illegal flag.

Parameters:
- DATA_W, 64, CSR data width.
- MSCRATCH_ADDR, 12'h340, address decoded to mrw_mscratch_sel.
- SSCRATCH_ADDR, 12'h140, address decoded to srw_sscratch_sel.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  pipeline CSR request.
- req_ready  out  1  pipeline request accepted this cycle.
- req_addr  in  12  CSR address.
- req_op  in  2  01=RW, 10=RS (set), 11=RC (clear), 00=illegal.
- req_wdata  in  DATA_W  rs1/immediate operand.
- req_rs1_zero  in  1  operand source is x0/zimm=0; suppresses the write for RS/RC.
- priv  in  2  current privilege (0=U, 1=S, 3=M).
- dbg_valid  in  1  debug access request.
- dbg_ready  out  1  debug request accepted.
- dbg_addr  in  12  debug CSR address.
- dbg_write  in  1  1=write dbg_wdata, 0=read only.
- dbg_wdata  in  DATA_W  debug write data.
- mscratch  in  DATA_W  current mscratch value.
- sscratch  in  DATA_W  current sscratch value.
- mrw_mscratch_sel  out  1  mscratch select.
- srw_sscratch_sel  out  1  sscratch select.
- csr_write  out  1  write strobe.
- data_csr  out  DATA_W  write data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_src  out  1  0=pipeline, 1=debug.
- rsp_rdata  out  DATA_W  pre-write CSR value (0 if illegal).
- rsp_illegal  out  1  access rejected.

Behaviour:
- Clock and reset: single clock clk; rst synchronous, active-high.
- Reset state:
  - FSM in IDLE.
  - All outputs 0.
  - Priority pointer set to debug.
  - A reset in any state aborts the access: no csr_write is issued and no rsp_valid is produced.
- FSM states: IDLE -> READ -> (WRITE) -> RESP -> IDLE.
- IDLE:
  - req_ready/dbg_ready are combinational, high only in IDLE and only for the granted source.
  - If only one source is valid, that source is granted.
  - If both are valid, the priority-pointer source is granted, and the pointer then moves to the other source (round-robin). A single-source grant also moves the pointer to the other source.
  - The handshake (valid & ready) latches addr, op, wdata, rs1_zero, source, and the effective privilege (priv for the pipeline, 3 for debug).
- READ (1 cycle):
  - Decode the latched address and compute legality.
  - Capture old = mscratch if addr==MSCRATCH_ADDR, sscratch if addr==SSCRATCH_ADDR.
  - Illegal if any of:
    - address is unmapped;
    - effective privilege < addr[9:8];
    - a write is intended and addr[11:10]==2'b11;
    - pipeline op==00.
  - Write intended when:
    - pipeline RW: always;
    - pipeline RS/RC: only when !rs1_zero;
    - debug: when dbg_write=1.
  - Next state: WRITE if legal and a write is intended, else RESP.
- WRITE (1 cycle):
  - Exactly one of mrw_mscratch_sel/srw_sscratch_sel is high, together with csr_write=1.
  - data_csr:
    - RW / debug write: wdata;
    - RS: old | wdata;
    - RC: old & ~wdata.
  - Selects, csr_write and data_csr are 0 in every other state. Both selects are never high together.
- RESP (1 cycle):
  - rsp_valid=1, rsp_src = latched source.
  - rsp_rdata = old, forced to 0 if illegal; rsp_illegal as computed.
  - The response is not backpressured.
- Latency, counting the handshake cycle as cycle 0:
  - write access: csr_write in cycle 2, rsp_valid in cycle 3;
  - read-only or illegal access: rsp_valid in cycle 2.
  - Next accept no earlier than the cycle after RESP. Throughput is one access per 3–4 cycles.
- Inputs sampled only at the handshake; changes after acceptance are ignored.

Test Plan:
- Pipeline RW, priv=3, addr 0x340, wdata 0xDEAD_BEEF, mscratch=0x1234 -> cycle 2: mrw_mscratch_sel=1, csr_write=1, data_csr=0xDEAD_BEEF; cycle 3: rsp_valid=1, rsp_rdata=0x1234, rsp_illegal=0.
- Pipeline RS on 0x140, sscratch=0xF0, wdata=0x0F, priv=1 -> data_csr=0xFF with srw_sscratch_sel=1. RC with wdata=0x30 from 0xFF -> data_csr=0xCF.
- Pipeline RS with req_rs1_zero=1, addr 0x340, priv=3 -> no csr_write; rsp_valid at cycle 2 with rsp_rdata=mscratch.
- Privilege fault: pipeline priv=1 accesses 0x340; unmapped addr 0x341 at priv=3 -> no write; rsp_illegal=1, rsp_rdata=0 for both.
- req_valid and dbg_valid held high together for 4 accesses right after reset -> grant order dbg, pipe, dbg, pipe; rsp_src=1,0,1,0.
- rst asserted during WRITE -> no csr_write in the reset cycle, no rsp_valid; all outputs 0 next cycle; a fresh request afterwards completes normally.
